os_scheduler: RTL
=================

Name: os_scheduler

Overview:
- Sequences the per-lane ordered-set symbol stream (TS1, TS2, SKP) that feeds the PIPE receive-side symbol driver.
- Selects which ordered set goes next from the requested training mode, and inserts SKP ordered sets on a fixed symbol interval.
- Counts completed training sets and reports when the count target is reached, so the LTSSM model can advance.
- Sits between the LTSSM state logic and the lane symbol driver; uses a valid/ready handshake on the symbol side.

Parameters:
- SKP_INTERVAL, 1180: accepted symbols between SKP insertion requests.
- TS1_TARGET, 1024: completed TS1 sets required to assert ts_done in TS1 mode.
- TS2_TARGET, 16: completed TS2 sets required to assert ts_done in TS2 mode.
- CNTW, 16: width of ts_sent_cnt and the SKP timer.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- en  in  1  scheduler enable
- mode  in  2  requested stream: 0=idle, 1=TS1, 2=TS2, 3=SKP-only
- ts_fields  in  40  TS symbols 1..5; [7:0]=symbol 1 … [39:32]=symbol 5
- sym_ready  in  1  downstream accepts the current symbol
- sym_data  out  8  current symbol
- sym_k  out  1  current symbol is a K-code
- sym_valid  out  1  sym_data/sym_k are valid
- os_type  out  2  ordered set in flight: 0=none, 1=TS1, 2=TS2, 3=SKP
- ts_sent_cnt  out  CNTW  completed TS sets in the current mode
- ts_done  out  1  ts_sent_cnt >= target for the current mode
- skp_pending  out  1  SKP is owed at the next ordered-set boundary

Behaviour:
- Reset (async, any time, including mid-set):
  - All outputs 0; FSM goes to IDLE.
  - Symbol index, SKP timer and latched fields are cleared.
- Handshake:
  - A symbol transfers on a clk edge where sym_valid && sym_ready.
  - While sym_valid=1 and sym_ready=0, sym_data, sym_k and os_type hold stable.
- FSM states:
  - IDLE: sym_valid=0, sym_data=0, os_type=0. On each clk with en=1 and mode!=0, load the next set (selection rule below) and move to SEND.
  - SEND: emit the set one symbol per transfer, idx 0..LEN-1. LEN=16 for TS, 4 for SKP.
  - After the transfer of the last symbol, take the boundary decision in the same edge:
    - en=1 and mode!=0: start the next set; no bubble, so sym_valid stays 1.
    - otherwise: go to IDLE.
- Selection priority at each boundary:
  - skp_pending=1 or mode=3: SKP.
  - else mode=1: TS1.
  - else mode=2: TS2.
- Mode and en are sampled only at set boundaries. A set in flight always completes, even if en drops or mode changes.
- Symbol encoding:
  - Symbol 0 of every set: COM = 8'hBC, k=1.
  - SKP symbols 1..3: 8'h1C, k=1.
  - TS symbols 1..5: the ts_fields bytes. k=1 only when the byte is PAD (8'hF7).
  - TS symbols 6..15: 8'h4A for TS1, 8'h45 for TS2; k=0.
  - ts_fields is latched when symbol 0 of a TS transfers. Later ts_fields changes do not affect the set in flight.
- SKP timer:
  - Increments on every transferred TS symbol. It does not count SKP symbols or idle cycles.
  - On reaching SKP_INTERVAL-1 with a transfer: set skp_pending and reset the timer to 0.
  - skp_pending clears when symbol 0 of the SKP set transfers.
  - If a new interval expiry coincides with that clear, set wins.
- TS counting:
  - ts_sent_cnt increments when symbol 15 of a TS transfers, saturating at all-ones.
  - Cleared to 0 at a boundary where the selected TS type differs from the last TS type sent, and on entry to IDLE.
  - Inserted SKP sets neither clear nor increment the count.
- ts_done is combinational: (os_type or last TS type = TS1 and cnt >= TS1_TARGET) or (TS2 and cnt >= TS2_TARGET). It is 0 in IDLE.
- Latency: first symbol becomes valid 1 clk after en=1 and mode!=0 are sampled in IDLE.

Test Plan:
- Reset, then en=1, mode=1, ts_fields=40'hF7_F7_0A_02_01, sym_ready=1:
  - Cycle 1: sym_valid=1, BC/k=1.
  - Then 01, 02, 0A (k=0); F7, F7 (k=1).
  - Then ten 4A; ts_sent_cnt=1 after symbol 15.
- Backpressure: sym_ready low for 5 clks at idx 7 of a TS2 → sym_data holds 8'h45, k=0, os_type=2. Stream resumes at idx 8 with no symbol lost or duplicated.
- SKP_INTERVAL=40, mode=1, sym_ready=1:
  - skp_pending asserts after 40 TS symbols (mid-set, symbol 7 of the 3rd TS).
  - At the next boundary, BC 1C 1C 1C with os_type=3; then TS1 resumes.
  - ts_sent_cnt continues unchanged across the SKP.
- TS2_TARGET=16, mode=2: ts_done=0 through 15 sets and =1 once the 16th symbol 15 transfers. Switching mode to 1 clears ts_sent_cnt to 0 at the next boundary and drops ts_done.
- Drop en at idx 3 of a TS1 → the set completes through idx 15, then sym_valid=0 and os_type=0.
- Assert reset at idx 9 of a TS1 → same cycle: sym_valid=0, sym_data=0, ts_sent_cnt=0, skp_pending=0. After release, the first set restarts at COM.

Source files
------------

// File: rtl/os_scheduler.sv
// Per-lane ordered-set scheduler: streams TS1/TS2/SKP symbols over a valid/ready
// handshake, inserts SKP on a symbol interval and counts completed training sets.
module os_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned TS1_TARGET   = 1024,
  parameter int unsigned TS2_TARGET   = 16,
  parameter int unsigned CNTW         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [39:0]     ts_fields,
  input  logic            sym_ready,
  output logic [7:0]      sym_data,
  output logic            sym_k,
  output logic            sym_valid,
  output logic [1:0]      os_type,
  output logic [CNTW-1:0] ts_sent_cnt,
  output logic            ts_done,
  output logic            skp_pending
);

  typedef enum logic {S_IDLE, S_SEND} state_t;
  typedef enum logic [1:0] {OS_NONE = 2'd0, OS_TS1 = 2'd1, OS_TS2 = 2'd2, OS_SKP = 2'd3} os_t;

  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  localparam logic [7:0] PAD     = 8'hF7;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;

  state_t          r_state, w_state_next;
  os_t             r_os, r_last_ts, w_sel, w_kind;
  logic [3:0]      r_idx;
  logic [39:0]     r_fields;
  logic [CNTW-1:0] r_cnt, r_timer;
  logic            r_skp_pending;

  logic            w_xfer, w_last, w_is_ts, w_expire, w_go, w_load, w_to_idle;
  logic [7:0]      w_field;

  assign w_xfer   = (r_state == S_SEND) && sym_ready;
  assign w_is_ts  = (r_os == OS_TS1) || (r_os == OS_TS2);
  assign w_last   = (r_os == OS_SKP) ? (r_idx == 4'd3) : (r_idx == 4'd15);
  assign w_expire = w_xfer && w_is_ts && (r_timer == CNTW'(SKP_INTERVAL - 1));
  assign w_go     = en && (mode != 2'd0);

  // An expiry on the very transfer that closes a set already owes SKP at this boundary.
  always_comb begin
    if (r_skp_pending || w_expire || mode == 2'd3) w_sel = OS_SKP;
    else if (mode == 2'd1)                        w_sel = OS_TS1;
    else                                          w_sel = OS_TS2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_next = r_state;
    w_load       = 1'b0;
    w_to_idle    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_next = S_SEND;
          w_load       = 1'b1;
        end
      end
      S_SEND: begin
        if (w_xfer && w_last) begin
          if (w_go) begin
            w_load = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_to_idle    = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: later non-blocking assignments in this block deliberately override earlier ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_os          <= OS_NONE;
      r_last_ts     <= OS_NONE;
      r_idx         <= '0;
      r_fields      <= '0;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_skp_pending <= 1'b0;
    end else begin
      if (w_xfer) r_idx <= r_idx + 4'd1;
      if (w_xfer && w_is_ts && r_idx == 4'd0) r_fields <= ts_fields;
      if (w_xfer && w_is_ts) r_timer <= w_expire ? '0 : r_timer + 1'b1;

      if (w_expire)                                         r_skp_pending <= 1'b1;
      else if (w_xfer && r_os == OS_SKP && r_idx == 4'd0) r_skp_pending <= 1'b0;

      if (w_xfer && w_is_ts && r_idx == 4'd15 && r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_idx <= '0;
        r_os  <= w_sel;
        if (w_sel != OS_SKP) begin
          r_last_ts <= w_sel;
          if (w_sel != r_last_ts) r_cnt <= '0;
        end
      end

      if (w_to_idle) begin
        r_idx     <= '0;
        r_os      <= OS_NONE;
        r_last_ts <= OS_NONE;
        r_cnt     <= '0;
      end
    end
  end

  always_comb begin
    case (r_idx)
      4'd1:    w_field = r_fields[7:0];
      4'd2:    w_field = r_fields[15:8];
      4'd3:    w_field = r_fields[23:16];
      4'd4:    w_field = r_fields[31:24];
      4'd5:    w_field = r_fields[39:32];
      default: w_field = 8'h00;
    endcase
  end

  always_comb begin
    sym_data = 8'h00;
    sym_k    = 1'b0;
    if (r_state == S_SEND) begin
      if (r_idx == 4'd0) begin
        sym_data = COM;
        sym_k    = 1'b1;
      end else if (r_os == OS_SKP) begin
        sym_data = SKP_SYM;
        sym_k    = 1'b1;
      end else if (r_idx <= 4'd5) begin
        sym_data = w_field;
        sym_k    = (w_field == PAD);
      end else begin
        sym_data = (r_os == OS_TS1) ? TS1_ID : TS2_ID;
      end
    end
  end

  // During an inserted SKP the done flag follows the last TS type sent.
  assign w_kind = w_is_ts ? r_os : r_last_ts;

  assign sym_valid   = (r_state == S_SEND);
  assign os_type     = sym_valid ? r_os : OS_NONE;
  assign ts_sent_cnt = r_cnt;
  assign skp_pending = r_skp_pending;
  assign ts_done     = sym_valid &&
                       (((w_kind == OS_TS1) && (r_cnt >= CNTW'(TS1_TARGET))) ||
                        ((w_kind == OS_TS2) && (r_cnt >= CNTW'(TS2_TARGET))));

endmodule
